axi_write_arbiter_rr: RTL and testbench
=======================================

# axi_write_arbiter_rr

Parametrised AXI write-channel arbiter sitting between N masters and the write-path muxes of the interconnect. Grants one master at a time using round-robin priority, decodes the captured AWADDR into a one-hot slave select (with a default slave for unmapped addresses), and holds the grant until that master's own B handshake completes. An optional watchdog releases a grant whose response never arrives.

## Interface
- NUM_MASTERS, 2: requesting masters, ≥2.
- NUM_SLAVES, 2: mapped slaves. The default slave is extra, at index NUM_SLAVES.
- ADDR_W, 32: address width.
- SEL_LSB, 16: lowest address bit of the slave index field.
- SEL_W, 1: width of the slave index field. Bits [ADDR_W-1:SEL_LSB+SEL_W] must be zero for a mapped hit.
- TIMEOUT, 1024: watchdog limit in cycles; only used with WR_ARB_TIMEOUT_EN.
- ACLK  in  1  clock; all logic on the rising edge.
- ARESET  in  1  reset, synchronous, active-high.
- AWADDR_M  in  NUM_MASTERS*ADDR_W  per-master write address; master i occupies [i*ADDR_W +: ADDR_W].
- AWVALID_M  in  NUM_MASTERS  per-master AW request.
- BVALID_M  in  NUM_MASTERS  per-master B valid, as seen at the master port.
- BREADY_M  in  NUM_MASTERS  per-master B ready.
- grant_o  out  NUM_MASTERS  one-hot grant; zero when idle.
- grant_idx_o  out  $clog2(NUM_MASTERS)  binary index of the granted master.
- slave_sel_o  out  NUM_SLAVES+1  one-hot target; MSB is the default slave (DECERR).
- busy_o  out  1  a grant is held.
- timeout_o  out  1  one-cycle pulse when the watchdog frees a grant; constant 0 without the macro.

## Operation
- Two states:
  - IDLE: no grant held.
  - GRANT: one master owns the write path.
- IDLE → GRANT, when any AWVALID_M bit is set:
  - Select the first requester at or after rr_ptr, searching upward with wrap-around.
  - Capture that master's index and AWADDR into registers.
- GRANT → IDLE, on BVALID_M[g] && BREADY_M[g] for the granted master g only.
  - B handshakes from other masters are ignored.
- On release, rr_ptr ← (g+1) mod NUM_MASTERS.
  - A master that has just finished therefore has lowest priority in the next arbitration.
- AWVALID changes while in GRANT have no effect. The captured address and index stay frozen.
- Decode, computed from the captured address only:
  - hit = (addr[ADDR_W-1:SEL_LSB+SEL_W] == 0) && (idx < NUM_SLAVES), where idx = addr[SEL_LSB +: SEL_W].
  - hit → slave_sel_o = 1<<idx.
  - Otherwise → slave_sel_o = 1<<NUM_SLAVES (default slave).
- In IDLE, grant_o and slave_sel_o are all zeros, and grant_idx_o is 0.

## Timing
- Reset values: state IDLE, rr_ptr 0, captured address 0, all outputs 0.
- ARESET high at any cycle, including mid-GRANT, returns everything to reset values at that edge. No response is awaited.
- Grant latency: request sampled in IDLE at edge t → grant_o, grant_idx_o, slave_sel_o and busy_o valid after edge t (registered). No combinational path from AWVALID/AWADDR to the outputs.
- Release: B handshake at edge t → state IDLE after t.
  - Earliest re-grant is edge t+1, so there is always at least one idle cycle between grants.
- A B handshake arriving while IDLE is ignored.
- With all masters requesting continuously, grants rotate 0,1,…,N-1,0.

## Configuration
- WR_ARB_TIMEOUT_EN defined:
  - A counter clears on entering GRANT and increments each cycle in GRANT.
  - The cycle it equals TIMEOUT-1 without a B handshake, the arbiter returns to IDLE, advances rr_ptr as for a normal release, and pulses timeout_o for one cycle.
  - A B handshake on that same cycle takes precedence: normal release, no pulse.
- WR_ARB_TIMEOUT_EN undefined: no counter, and timeout_o is tied to 0.

## Structure
- Shared package axi_arb_pkg:
  - arb_state_e {IDLE, GRANT}.
  - Function for slave-select decode.
  - Default-slave index convention.
- One sub-module, rr_pick: combinational round-robin selector.
  - Inputs: request vector, pointer.
  - Outputs: one-hot grant, index, any.

## Test plan
- Reset: assert ARESET for 2 cycles mid-GRANT (N=2) → next cycle all outputs 0 and rr_ptr 0. A subsequent request from M1 alone is granted.
- Decode: M0 AWADDR=0x0001_0000 → slave_sel_o=3'b010. 0x0000_1234 → 3'b001. 0x0002_0000 → 3'b100 (default).
- Round-robin: N=3, all AWVALID held high, each grant ended by a B handshake 3 cycles later → grant_idx_o sequence 0,1,2,0. One idle cycle between grants.
- Foreign response: M0 granted, BVALID_M1&&BREADY_M1 pulses → grant held. BVALID_M0&&BREADY_M0 → release next edge.
- Address hold: change AWADDR_M0 from 0x0 to 0xFFFF_0000 during GRANT → slave_sel_o stays 3'b001.
- Timeout (macro on, TIMEOUT=8): grant with no B → timeout_o pulses once, 8 cycles after entry. Next requester is granted the following cycle.

Source files
------------

// File: rtl/axi_arb_pkg.sv
// Shared types and address-decode helpers for the AXI write-channel arbiter.
// The default (DECERR) slave always sits one index above the last mapped slave.
package axi_arb_pkg;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } arb_state_e;

    function automatic int default_slave_idx(input int num_slaves);
        return num_slaves;
    endfunction

    // Address is passed zero-extended to 64 bits so one function serves any ADDR_W <= 64.
    function automatic int slave_decode(input logic [63:0] addr,
                                        input int          sel_lsb,
                                        input int          sel_w,
                                        input int          num_slaves);
        logic [63:0] upper;
        logic [63:0] field;
        int          idx;
        upper = addr >> (sel_lsb + sel_w);
        field = (addr >> sel_lsb) & ((64'd1 << sel_w) - 64'd1);
        idx   = int'(field);
        if (upper == 64'd0 && idx < num_slaves)
            return idx;
        return default_slave_idx(num_slaves);
    endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin selector: first set request at or after ptr,
// searching upward with wrap-around.
module rr_pick #(
    parameter int N  = 2,
    parameter int IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic [N-1:0]  gnt,
    output logic [IW-1:0] idx,
    output logic          any
);

    always_comb begin
        int          j;
        logic [IW-1:0] j_i;
        gnt = '0;
        idx = '0;
        any = |req;
        j   = 0;
        j_i = '0;
        // Walk from farthest to nearest so the nearest requester wins last.
        for (int k = N - 1; k >= 0; k--) begin
            j = int'(ptr) + k;
            if (j >= N)
                j = j - N;
            j_i = IW'(j);
            if (req[j_i]) begin
                gnt      = '0;
                gnt[j_i] = 1'b1;
                idx      = j_i;
            end
        end
    end

endmodule

// File: rtl/axi_write_arbiter_rr.sv
// Round-robin AXI write arbiter: holds one master's grant until its own B
// handshake. Define WR_ARB_TIMEOUT_EN to add a watchdog that frees stuck grants.
module axi_write_arbiter_rr
    import axi_arb_pkg::*;
#(
    parameter int NUM_MASTERS = 2,
    parameter int NUM_SLAVES  = 2,
    parameter int ADDR_W      = 32,
    parameter int SEL_LSB     = 16,
    parameter int SEL_W       = 1,
    parameter int TIMEOUT     = 1024,
    localparam int IDX_W      = $clog2(NUM_MASTERS)
) (
    input  logic                          ACLK,
    input  logic                          ARESET,
    input  logic [NUM_MASTERS*ADDR_W-1:0] AWADDR_M,
    input  logic [NUM_MASTERS-1:0]        AWVALID_M,
    input  logic [NUM_MASTERS-1:0]        BVALID_M,
    input  logic [NUM_MASTERS-1:0]        BREADY_M,
    output logic [NUM_MASTERS-1:0]        grant_o,
    output logic [IDX_W-1:0]              grant_idx_o,
    output logic [NUM_SLAVES:0]           slave_sel_o,
    output logic                          busy_o,
    output logic                          timeout_o
);

    if (NUM_MASTERS < 2 || NUM_SLAVES < 1 || TIMEOUT < 2 ||
        SEL_LSB + SEL_W > ADDR_W || ADDR_W > 64) begin : g_bad_params
        $error("axi_write_arbiter_rr: illegal parameter combination");
    end

    arb_state_e               state;
    logic [IDX_W-1:0]         rr_ptr;
    logic [IDX_W-1:0]         grant_idx;
    logic [NUM_MASTERS-1:0]   grant_q;
    logic [ADDR_W-1:0]        cap_addr;

    logic [NUM_MASTERS-1:0]   pick_gnt;
    logic [IDX_W-1:0]         pick_idx;
    logic                     pick_any;
    logic                     b_done;
    logic                     wd_fire;
    logic                     release_now;
    logic [IDX_W-1:0]         next_ptr;

    rr_pick #(
        .N  (NUM_MASTERS),
        .IW (IDX_W)
    ) u_pick (
        .req (AWVALID_M),
        .ptr (rr_ptr),
        .gnt (pick_gnt),
        .idx (pick_idx),
        .any (pick_any)
    );

    // Only the owner's B handshake ends the grant; other masters' responses are ignored.
    assign b_done      = (state == GRANT) && BVALID_M[grant_idx] && BREADY_M[grant_idx];
    assign release_now = b_done || wd_fire;
    assign next_ptr    = (int'(grant_idx) == NUM_MASTERS - 1) ? '0 : grant_idx + 1'b1;

    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            state     <= IDLE;
            rr_ptr    <= '0;
            grant_idx <= '0;
            grant_q   <= '0;
            cap_addr  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (pick_any) begin
                        state     <= GRANT;
                        grant_q   <= pick_gnt;
                        grant_idx <= pick_idx;
                        cap_addr  <= AWADDR_M[int'(pick_idx)*ADDR_W +: ADDR_W];
                    end
                end
                GRANT: begin
                    if (release_now) begin
                        state     <= IDLE;
                        grant_q   <= '0;
                        grant_idx <= '0;
                        rr_ptr    <= next_ptr;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef WR_ARB_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT);
    logic [CW-1:0] wd_cnt;
    logic          to_q;

    assign wd_fire   = (state == GRANT) && (wd_cnt == CW'(TIMEOUT - 1));
    assign timeout_o = to_q;

    // Held at zero while idle, so every grant starts counting from 0.
    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            wd_cnt <= '0;
            to_q   <= 1'b0;
        end else begin
            to_q <= wd_fire && !b_done;
            if (state == IDLE)
                wd_cnt <= '0;
            else
                wd_cnt <= wd_cnt + 1'b1;
        end
    end
`else
    assign wd_fire   = 1'b0;
    assign timeout_o = 1'b0;
`endif

    always_comb begin
        int sel_idx;
        sel_idx     = slave_decode(64'(cap_addr), SEL_LSB, SEL_W, NUM_SLAVES);
        busy_o      = (state == GRANT);
        grant_o     = grant_q;
        grant_idx_o = grant_idx;
        slave_sel_o = busy_o ? ((NUM_SLAVES + 1)'(1) << sel_idx) : '0;
    end

endmodule

// File: tb/tb_axi_write_arbiter_rr.sv
// Self-checking bench for axi_write_arbiter_rr (3 masters, 2 slaves, TIMEOUT=8):
// directed scenarios with literal expectations plus randomized traffic vs. a behavioural model.
module tb_axi_write_arbiter_rr;

    localparam int N  = 3;
    localparam int NS = 2;
    localparam int AW = 32;
    localparam int SL = 16;
    localparam int SW = 1;
    localparam int TO = 8;
    localparam int IW = 2;

    logic            clk = 1'b0;
    logic            rst;
    logic [N*AW-1:0] awaddr;
    logic [N-1:0]    awvalid, bvalid, bready;
    logic [N-1:0]    grant;
    logic [IW-1:0]   grant_idx;
    logic [NS:0]     slave_sel;
    logic            busy, tmo;

    int tests = 0;
    int fails = 0;
    bit chk_en = 0;

    // model state
    bit          m_busy;
    int          m_g;
    logic [AW-1:0] m_addr;
    int          m_ptr;
    int          m_age;
    bit          m_to;

    always #5 clk = ~clk;

    axi_write_arbiter_rr #(
        .NUM_MASTERS (N),
        .NUM_SLAVES  (NS),
        .ADDR_W      (AW),
        .SEL_LSB     (SL),
        .SEL_W       (SW),
        .TIMEOUT     (TO)
    ) dut (
        .ACLK        (clk),
        .ARESET      (rst),
        .AWADDR_M    (awaddr),
        .AWVALID_M   (awvalid),
        .BVALID_M    (bvalid),
        .BREADY_M    (bready),
        .grant_o     (grant),
        .grant_idx_o (grant_idx),
        .slave_sel_o (slave_sel),
        .busy_o      (busy),
        .timeout_o   (tmo)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic logic [NS:0] exp_sel(input logic [AW-1:0] a);
        logic [AW-1:0] upper;
        int idx;
        upper = a >> (SL + SW);
        idx   = int'((a >> SL) % (1 << SW));
        if (upper == 0 && idx < NS) return (NS+1)'(1) << idx;
        return (NS+1)'(1) << NS;
    endfunction

    task automatic model_step();
        bit found;
        if (rst) begin
            m_busy = 0; m_g = 0; m_addr = '0; m_ptr = 0; m_age = 0; m_to = 0;
            return;
        end
        m_to = 0;
        if (m_busy) begin
            m_age++;
            if (bvalid[m_g] && bready[m_g]) begin
                m_busy = 0;
                m_ptr  = (m_g + 1) % N;
            end
`ifdef WR_ARB_TIMEOUT_EN
            else if (m_age == TO) begin
                m_busy = 0;
                m_ptr  = (m_g + 1) % N;
                m_to   = 1;
            end
`endif
        end else if (awvalid != '0) begin
            found = 0;
            for (int k = 0; k < N; k++) begin
                if (!found && awvalid[(m_ptr + k) % N]) begin
                    m_g   = (m_ptr + k) % N;
                    found = 1;
                end
            end
            m_busy = 1;
            m_addr = awaddr[m_g*AW +: AW];
            m_age  = 0;
        end
    endtask

    always @(posedge clk) model_step();

    // Single per-cycle comparison of all outputs against the model.
    always @(negedge clk) begin
        logic [9:0] e, a;
        if (chk_en) begin
            e = {m_busy ? N'(1) << m_g : N'(0),
                 m_busy ? IW'(m_g) : IW'(0),
                 m_busy ? exp_sel(m_addr) : (NS+1)'(0),
                 m_busy, m_to};
            a = {grant, grant_idx, slave_sel, busy, tmo};
            chk("model_cmp", 32'(a), 32'(e));
        end
    end

    task automatic do_txn(input int m, input logic [AW-1:0] addr, input logic [NS:0] sel);
        awaddr[m*AW +: AW] = addr;
        awvalid = '0; awvalid[m] = 1'b1;
        @(negedge clk);
        chk("txn_grant", 32'(grant), 32'(1 << m));
        chk("txn_sel", 32'(slave_sel), 32'(sel));
        awvalid = '0;
        @(negedge clk);
        bvalid[m] = 1'b1; bready[m] = 1'b1;
        @(negedge clk);
        bvalid = '0; bready = '0;
        chk("txn_release", 32'(busy), 32'd0);
    endtask

    task automatic do_reset(input int cycles);
        rst = 1'b1;
        repeat (cycles) @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        int n;
        int rr_exp [4] = '{0, 1, 2, 0};
        rst = 1'b1; awaddr = '0; awvalid = '0; bvalid = '0; bready = '0;
        @(negedge clk);
        chk_en = 1;
        @(negedge clk);
        chk("reset_outputs", 32'({grant, grant_idx, slave_sel, busy, tmo}), 32'd0);
        rst = 1'b0;

        // decode
        do_txn(0, 32'h0001_0000, 3'b010);
        do_txn(0, 32'h0000_1234, 3'b001);
        do_txn(0, 32'h0002_0000, 3'b100);

        // address hold while granted
        awaddr[0 +: AW] = 32'h0; awvalid = 3'b001;
        @(negedge clk);
        awvalid = '0; awaddr[0 +: AW] = 32'hFFFF_0000;
        @(negedge clk);
        chk("addr_hold", 32'(slave_sel), 32'b001);
        @(negedge clk);
        chk("addr_hold2", 32'(slave_sel), 32'b001);
        // foreign response ignored
        bvalid = 3'b010; bready = 3'b010;
        @(negedge clk);
        chk("foreign_b_busy", 32'(busy), 32'd1);
        chk("foreign_b_grant", 32'(grant), 32'b001);
        bvalid = 3'b001; bready = 3'b001;
        @(negedge clk);
        bvalid = '0; bready = '0;
        chk("own_b_release", 32'(busy), 32'd0);

        // round-robin with all masters requesting
        do_reset(1);
        awaddr = '0; awvalid = 3'b111;
        for (int i = 0; i < 4; i++) begin
            n = 0;
            while (!busy && n < 10) begin @(negedge clk); n++; end
            chk("rr_grant_seen", 32'(busy), 32'd1);
            chk("rr_idx", 32'(grant_idx), 32'(rr_exp[i]));
            repeat (2) @(negedge clk);
            bvalid = 3'b111; bready = 3'b111;
            @(negedge clk);
            bvalid = '0; bready = '0;
            chk("rr_idle_gap", 32'(busy), 32'd0);
        end
        awvalid = '0;
        @(negedge clk);

        // reset mid-grant; pointer must return to 0
        awvalid = 3'b010;
        @(negedge clk);
        chk("pre_reset_grant", 32'(grant_idx), 32'd1);
        awvalid = '0;
        do_reset(2);
        chk("midgrant_reset", 32'({grant, grant_idx, slave_sel, busy, tmo}), 32'd0);
        awvalid = 3'b111;
        @(negedge clk);
        chk("ptr_after_reset", 32'(grant_idx), 32'd0);
        awvalid = '0;
        bvalid = 3'b001; bready = 3'b001;
        @(negedge clk);
        bvalid = '0; bready = '0;
        awvalid = 3'b010;
        @(negedge clk);
        chk("m1_alone", 32'(grant), 32'b010);
        awvalid = '0;
        bvalid = 3'b010; bready = 3'b010;
        @(negedge clk);
        bvalid = '0; bready = '0;

        // watchdog
        do_reset(1);
        awvalid = 3'b100;
        @(negedge clk);
        chk("wd_grant", 32'(grant_idx), 32'd2);
        awvalid = 3'b001;
`ifdef WR_ARB_TIMEOUT_EN
        n = 0;
        while (n < 20) begin
            @(negedge clk); n++;
            if (tmo) break;
        end
        chk("wd_latency", 32'(n), 32'd8);
        chk("wd_idle", 32'(busy), 32'd0);
        @(negedge clk);
        chk("wd_next_grant", 32'(grant_idx), 32'd0);
        chk("wd_single_pulse", 32'(tmo), 32'd0);
        chk("wd_next_busy", 32'(busy), 32'd1);
`else
        repeat (20) @(negedge clk);
        chk("no_wd_busy", 32'(busy), 32'd1);
        chk("no_wd_tmo", 32'(tmo), 32'd0);
`endif
        awvalid = '0;
        bvalid = 3'b111; bready = 3'b111;
        @(negedge clk);
        bvalid = '0; bready = '0;

        // randomized traffic
        for (int c = 0; c < 3000; c++) begin
            rst     = ($urandom_range(0, 149) == 0);
            awvalid = N'($urandom_range(0, 7));
            bvalid  = N'($urandom);
            bready  = N'($urandom);
            for (int m = 0; m < N; m++) begin
                case ($urandom_range(0, 5))
                    0: awaddr[m*AW +: AW] = 32'h0000_0000;
                    1: awaddr[m*AW +: AW] = 32'h0001_0000;
                    2: awaddr[m*AW +: AW] = 32'h0002_0000;
                    3: awaddr[m*AW +: AW] = 32'h0000_1234;
                    4: awaddr[m*AW +: AW] = 32'hFFFF_0000;
                    default: awaddr[m*AW +: AW] = $urandom;
                endcase
            end
            @(negedge clk);
        end
        rst = 1'b0; awvalid = '0; bvalid = '0; bready = '0;
        @(negedge clk);
        chk_en = 0;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
